ic_74157_demux: RTL and testbench
=================================

Name: ic_74157_demux

Overview:
- Receive-end companion of the quad 2-input noninverting multiplexer. It sits on the far side of a 4-bit time-multiplexed bus whose select line S alternates between channel 0 (S=0) and channel 1 (S=1).
- Captures each channel into its own register and pairs one channel-0 sample with the following channel-1 sample into a frame.
- Publishes frames with a one-cycle strobe, counts them, and flags a stuck select line and discarded partial frames.

Parameters:
- WIDTH, 4, bus/channel data width
- STUCK_LIMIT, 8, consecutive enabled cycles with unchanged S before stuck flag asserts (2..255)
- CNT_WIDTH, 8, width of frame counter

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- Y  input  WIDTH  multiplexed data bus
- S  input  1  select observed alongside Y; 0 = channel 0, 1 = channel 1
- E  input  1  active-LOW enable; bus content is valid only when E=0
- A  output  WIDTH  last published channel-0 data
- B  output  WIDTH  last published channel-1 data
- pair_valid  output  1  one-cycle pulse when A/B update
- frame_cnt  output  CNT_WIDTH  number of frames published, wraps modulo 2^CNT_WIDTH
- stuck  output  1  S unchanged for STUCK_LIMIT enabled cycles
- dropped  output  1  sticky: a partial frame was discarded

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values (rst=1 at an edge): A=0, B=0, pair_valid=0, frame_cnt=0, stuck=0, dropped=0, FSM=WAIT0, hold register=0, run counter=0, last_S=0. Reset overrides all other activity, including a frame in progress; the partial frame is discarded and dropped is NOT set by reset.
- An enabled sample is an edge with E=0. Edges with E=1 never capture data.
- FSM states: WAIT0, HAVE0.
  - WAIT0, enabled S=0: hold<=Y, go HAVE0.
  - WAIT0, enabled S=1: ignore (orphan channel-1 sample), stay WAIT0, no flag.
  - WAIT0, E=1: stay.
  - HAVE0, enabled S=0: hold<=Y (newer sample replaces older), stay HAVE0, no flag.
  - HAVE0, enabled S=1: A<=hold, B<=Y, pair_valid<=1, frame_cnt<=frame_cnt+1, go WAIT0.
  - HAVE0, E=1: discard hold, dropped<=1, go WAIT0.
- Latency: A, B and pair_valid are visible the cycle after the edge that sampled channel 1. pair_valid is high for exactly one cycle and is never asserted on back-to-back cycles, because a minimum frame is 2 enabled cycles.
- A and B hold their values between frames. frame_cnt wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Stuck detection:
  - Run counter increments on each enabled edge where S equals last_S, saturating at STUCK_LIMIT.
  - On an enabled edge where S differs from last_S, the run counter resets to 1 and stuck<=0.
  - last_S updates on every enabled edge.
  - stuck<=1 on the edge where the run counter reaches STUCK_LIMIT.
  - E=1 cycles neither advance nor clear the run counter.
  - The first enabled edge after reset counts as a change if S=1; if S=0 it is a repeat of last_S=0.
- dropped: sticky until rst.
- Simultaneous events: when a frame completes on the same edge the stuck condition clears, both take effect.

Test Plan:
1. Reset, then E=0 with (S,Y) = (0,0x3) then (1,0xA) -> next cycle A=0x3, B=0xA, pair_valid=1 for one cycle, frame_cnt=1, stuck=0, dropped=0.
2. E=0 with (0,0x1),(0,0x2),(1,0x7) -> A=0x2, B=0x7, one pair_valid pulse, frame_cnt increments by 1.
3. E=0 (0,0x5), then E=1 for one cycle, then E=0 (1,0x9) -> no pair_valid, dropped=1, A/B unchanged; a subsequent (0,0xC),(1,0xD) publishes A=0xC, B=0xD with dropped still 1.
4. E=0 with S=1 held for 8 cycles after a prior S=0 sample, STUCK_LIMIT=8 -> stuck=1 after the 8th S=1 edge; next enabled S=0 edge -> stuck=0.
5. 256 complete frames with CNT_WIDTH=8 -> frame_cnt returns to 0, pair_valid pulsed 256 times.
6. Assert rst in HAVE0 (after (0,0xF)) -> all outputs 0, dropped=0; then (1,0x4) alone produces no pair_valid.

Source files
------------

// File: rtl/ic_74157_demux.sv
// ---------------------------------------------------------------------------
// ic_74157_demux
//   Receive-end companion of a quad 2-input multiplexer. A WIDTH-bit bus Y is
//   time-shared between channel 0 (S=0) and channel 1 (S=1). Bus content is
//   valid only when the active-low enable E is 0. Each channel-0 sample is
//   held until the next channel-1 sample. The pair is then published on A/B
//   with a one-cycle pair_valid strobe, and the frame is counted.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   Y          : multiplexed data bus (WIDTH)
//   S          : channel select observed with Y (0 = ch0, 1 = ch1)
//   E          : active-low enable; only E=0 edges sample the bus
//   A          : last published channel-0 data (WIDTH)
//   B          : last published channel-1 data (WIDTH)
//   pair_valid : one-cycle pulse when A/B update
//   frame_cnt  : published frame count, wraps (CNT_WIDTH)
//   stuck      : S unchanged for STUCK_LIMIT consecutive enabled edges
//   dropped    : sticky, a held channel-0 sample was discarded by E=1
// ---------------------------------------------------------------------------
module ic_74157_demux #(
  parameter int WIDTH       = 4,
  parameter int STUCK_LIMIT = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     Y,
  input  logic                 S,
  input  logic                 E,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic                 pair_valid,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 stuck,
  output logic                 dropped
);

  typedef enum logic {
    WAIT0 = 1'b0,
    HAVE0 = 1'b1
  } state_t;

  localparam logic [7:0] RUN_LIMIT = STUCK_LIMIT[7:0];

  state_t           state_p0;
  state_t           state_nxt;
  logic             en;
  logic             load_hold;
  logic             publish;
  logic             drop;
  logic [WIDTH-1:0] hold_p0;
  logic [7:0]       run_cnt_p0;
  logic [7:0]       run_cnt_nxt;
  logic             last_s_p0;

  // Run counter advance, parked at the limit so it can never wrap back below.
  function automatic logic [7:0] run_sat_inc(input logic [7:0] run);
    if (run >= RUN_LIMIT) return RUN_LIMIT;
    return run + 8'd1;
  endfunction

  assign en          = ~E;
  assign run_cnt_nxt = run_sat_inc(run_cnt_p0);

  // Frame FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_p0 <= WAIT0;
    else     state_p0 <= state_nxt;
  end

  // Frame FSM: next state
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      WAIT0: if (en && !S) state_nxt = HAVE0;
      HAVE0: if (!en || S) state_nxt = WAIT0;
      default: state_nxt = WAIT0;
    endcase
  end

  // Frame FSM: actions. A channel-0 sample is captured in either state,
  // so a newer channel-0 sample simply overwrites the held one.
  always_comb begin
    load_hold = 1'b0;
    publish   = 1'b0;
    drop      = 1'b0;
    case (state_p0)
      WAIT0: load_hold = en && !S;
      HAVE0: begin
        load_hold = en && !S;
        publish   = en && S;
        drop      = !en;
      end
      default: ;
    endcase
  end

  // Stage p0 -> outputs: hold register and published frame
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_p0    <= '0;
      A          <= '0;
      B          <= '0;
      pair_valid <= 1'b0;
      frame_cnt  <= '0;
      dropped    <= 1'b0;
    end else begin
      pair_valid <= publish;
      if (load_hold) hold_p0 <= Y;
      if (publish) begin
        A         <= hold_p0;
        B         <= Y;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (drop) dropped <= 1'b1;
    end
  end

  // Stuck-select detector. Disabled cycles freeze the run; last_s resets
  // to 0, so a first enabled S=0 extends that run rather than starting one.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_p0 <= '0;
      last_s_p0  <= 1'b0;
      stuck      <= 1'b0;
    end else if (en) begin
      last_s_p0 <= S;
      if (S == last_s_p0) begin
        run_cnt_p0 <= run_cnt_nxt;
        if (run_cnt_nxt == RUN_LIMIT) stuck <= 1'b1;
      end else begin
        run_cnt_p0 <= 8'd1;
        stuck      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ic_74157_demux.sv
module tb_ic_74157_demux;

  localparam int W     = 4;
  localparam int LIMIT = 8;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  Y   = '0;
  logic          S   = 1'b0;
  logic          E   = 1'b1;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          pair_valid;
  logic [CW-1:0] frame_cnt;
  logic          stuck;
  logic          dropped;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending channel-0 sample as a queue (0 or 1 entries),
  // recent enabled S values as a bounded history window.
  logic [W-1:0] pend_q[$];
  bit           hist_q[$];
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  logic         exp_pv;
  int           frames;
  logic         exp_drop;
  int           pulses;

  ic_74157_demux #(.WIDTH(W), .STUCK_LIMIT(LIMIT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .Y(Y), .S(S), .E(E),
    .A(A), .B(B), .pair_valid(pair_valid), .frame_cnt(frame_cnt),
    .stuck(stuck), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_stuck();
    if (hist_q.size() < LIMIT) return 1'b0;
    foreach (hist_q[i]) if (hist_q[i] != hist_q[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_A"},     32'(A),          32'(exp_a));
    check({tag, "_B"},     32'(B),          32'(exp_b));
    check({tag, "_pv"},    32'(pair_valid), 32'(exp_pv));
    check({tag, "_cnt"},   32'(frame_cnt),  32'(frames % (1 << CW)));
    check({tag, "_stuck"}, 32'(stuck),      32'(model_stuck()));
    check({tag, "_drop"},  32'(dropped),    32'(exp_drop));
  endtask

  task automatic do_reset();
    rst = 1'b1; E = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pend_q.delete(); hist_q.delete();
    exp_a = '0; exp_b = '0; exp_pv = 1'b0; frames = 0; exp_drop = 1'b0;
    check_all("reset");
  endtask

  task automatic step(input string tag, input logic e, input logic s, input logic [W-1:0] y);
    E = e; S = s; Y = y;
    @(posedge clk); #1;
    exp_pv = 1'b0;
    if (!e) begin
      if (!s) begin
        pend_q.delete();
        pend_q.push_back(y);
      end else if (pend_q.size() > 0) begin
        exp_a  = pend_q.pop_front();
        exp_b  = y;
        exp_pv = 1'b1;
        frames++;
      end
      hist_q.push_back(s);
      if (hist_q.size() > LIMIT) void'(hist_q.pop_front());
    end else if (pend_q.size() > 0) begin
      exp_drop = 1'b1;
      pend_q.delete();
    end
    if (pair_valid) pulses++;
    check_all(tag);
  endtask

  initial begin
    // 1: basic frame
    do_reset();
    step("t1a", 1'b0, 1'b0, 4'h3);
    step("t1b", 1'b0, 1'b1, 4'hA);
    check("t1_A_const", 32'(A), 32'h3);
    check("t1_B_const", 32'(B), 32'hA);
    check("t1_pv_const", 32'(pair_valid), 32'h1);
    step("t1c", 1'b1, 1'b0, 4'h0);
    check("t1_pv_off", 32'(pair_valid), 32'h0);

    // 2: newer channel-0 sample replaces older
    step("t2a", 1'b0, 1'b0, 4'h1);
    step("t2b", 1'b0, 1'b0, 4'h2);
    step("t2c", 1'b0, 1'b1, 4'h7);
    check("t2_A_const", 32'(A), 32'h2);
    check("t2_cnt_const", 32'(frame_cnt), 32'h2);

    // 3: partial frame discarded by a disabled cycle
    step("t3a", 1'b0, 1'b0, 4'h5);
    step("t3b", 1'b1, 1'b0, 4'h6);
    step("t3c", 1'b0, 1'b1, 4'h9);
    check("t3_drop_const", 32'(dropped), 32'h1);
    step("t3d", 1'b0, 1'b0, 4'hC);
    step("t3e", 1'b0, 1'b1, 4'hD);
    check("t3_B_const", 32'(B), 32'hD);

    // 4: stuck select, then cleared by a change
    step("t4a", 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < LIMIT; i++) step("t4run", 1'b0, 1'b1, W'(i));
    check("t4_stuck_const", 32'(stuck), 32'h1);
    step("t4gap", 1'b1, 1'b1, 4'h0);
    step("t4clr", 1'b0, 1'b0, 4'h8);
    check("t4_clr_const", 32'(stuck), 32'h0);

    // 5: full counter wrap
    do_reset();
    pulses = 0;
    for (int i = 0; i < (1 << CW); i++) begin
      step("t5a", 1'b0, 1'b0, W'($urandom));
      step("t5b", 1'b0, 1'b1, W'($urandom));
    end
    check("t5_cnt_wrap", 32'(frame_cnt), 32'h0);
    check("t5_pulses", 32'(pulses), 32'(1 << CW));

    // 6: reset mid-frame
    step("t6a", 1'b0, 1'b0, 4'hF);
    do_reset();
    step("t6b", 1'b0, 1'b1, 4'h4);
    check("t6_pv_const", 32'(pair_valid), 32'h0);

    // Long S=0 run from reset
    do_reset();
    for (int i = 0; i < LIMIT + 3; i++) step("s0run", 1'b0, 1'b0, W'($urandom));

    // Random traffic
    for (int i = 0; i < 600; i++)
      step("rnd", ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), W'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
